cache_line_arbiter: RTL and testbench
=====================================

Name: cache_line_arbiter

Overview:
- Arbitrates between the instruction-cache core and the data-cache core; both present a 256-bit line-granular downstream interface.
- Funnels their misses and write-backs into a single line interface toward the L2 / physical memory.
- Sits directly downstream of each cache core's downstream port.
- Serves one transaction at a time, with round-robin fairness when both caches request together.

Parameters:
- s_line, 256, line width in bits.
- s_addr, 32, address width in bits.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- i_read  input  1  I-side read request, held until i_resp
- i_write  input  1  I-side write request, held until i_resp
- i_address  input  s_addr  I-side line address
- i_wdata  input  s_line  I-side write line
- i_resp  output  1  I-side completion pulse
- i_rdata  output  s_line  I-side read line, valid with i_resp
- d_read, d_write, d_address, d_wdata  input  1/1/s_addr/s_line  D-side request, same rules as I-side
- d_resp  output  1  D-side completion pulse
- d_rdata  output  s_line  D-side read line
- mem_read  output  1  downstream read request
- mem_write  output  1  downstream write request
- mem_address  output  s_addr  downstream address
- mem_wdata  output  s_line  downstream write line
- mem_resp  input  1  downstream completion pulse (one cycle)
- mem_rdata  input  s_line  downstream read line, valid with mem_resp

Behaviour:
- Single clock clk; reset rst is synchronous and active-high.
- Reset:
  - State goes to IDLE and last_served goes to I.
  - All outputs are 0: mem_read, mem_write, i_resp, d_resp, mem_address, mem_wdata.
- States:
  - IDLE: no downstream request driven. Evaluates requests each cycle (req_x = x_read | x_write).
    - Only one side requesting: that side is granted.
    - Both requesting: the side not equal to last_served is granted (D wins the first tie after reset).
    - A grant sets next state to SERVE_I or SERVE_D and updates last_served.
    - No request: stay IDLE.
  - SERVE_I / SERVE_D: combinationally route the granted side's signals to the mem_* ports.
    - mem_write = x_write.
    - mem_read = x_read & ~x_write; a client asserting both is treated as a write.
    - mem_address = x_address; mem_wdata = x_wdata.
    - The ungranted side's signals are ignored and its resp is held 0.
- Completion:
  - In SERVE_x with mem_resp=1: x_resp=1 in that same cycle (combinational), next state is IDLE.
  - x_resp is never asserted outside that cycle.
- Latency:
  - Request seen in IDLE at cycle t; mem_* asserted from t+1.
  - Client resp coincides with mem_resp.
  - One IDLE bubble is required between consecutive transactions.
- rdata: i_rdata = d_rdata = mem_rdata unconditionally. Clients sample only on their own resp.
- Request withdrawn: if the granted side drops both read and write while in SERVE_x without mem_resp, the arbiter returns to IDLE next cycle and mem_* deassert that cycle. last_served keeps the withdrawn side.
- mem_resp in IDLE: ignored, no client resp generated.
- mem_resp in the same cycle as rst: reset wins; no resp is forwarded.
- Reset mid-transaction: abandons the transaction, no resp is forwarded, state goes to IDLE. Downstream is reset together with the arbiter.
- Starvation bound: a continuously requesting side waits at most one other transaction.

Test Plan:
- Reset, then i_read=1, i_address=0x0000_1000, mem_resp pulsed at cycle 5 with mem_rdata=0xA5…A5:
  - mem_read=1 and mem_address=0x1000 from cycle 1.
  - i_resp=1 and i_rdata=0xA5…A5 at cycle 5.
  - d_resp stays 0; back to IDLE at cycle 6.
- After reset, i_read and d_write asserted in the same cycle:
  - D served first: mem_write=1, mem_address=d_address, mem_wdata=d_wdata.
  - After d_resp, one IDLE cycle, then I served with mem_read=1.
- Both sides requesting continuously for 6 transactions → grants alternate D,I,D,I,D,I and no side ever waits two transactions.
- d_read=d_write=1 with d_address=0x40 → mem_write=1, mem_read=0, mem_address=0x40.
- Spurious mem_resp=1 in IDLE → i_resp=d_resp=0, state stays IDLE.
- rst=1 asserted while in SERVE_I, then mem_resp pulsed the following cycle → no i_resp, all mem_* =0, state IDLE.

Source files
------------

// File: rtl/cache_line_arbiter.sv
// Two-client line arbiter: funnels I-cache and D-cache misses and write-backs
// into one downstream line port, one transaction at a time, round-robin on ties.
module cache_line_arbiter #(
    parameter int s_line = 256,
    parameter int s_addr = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic              i_write,
    input  logic [s_addr-1:0] i_address,
    input  logic [s_line-1:0] i_wdata,
    output logic              i_resp,
    output logic [s_line-1:0] i_rdata,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [s_addr-1:0] d_address,
    input  logic [s_line-1:0] d_wdata,
    output logic              d_resp,
    output logic [s_line-1:0] d_rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [s_addr-1:0] mem_address,
    output logic [s_line-1:0] mem_wdata,
    input  logic              mem_resp,
    input  logic [s_line-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        SERVE_I,
        SERVE_D
    } state_t;

    typedef enum logic {
        SIDE_I,
        SIDE_D
    } side_t;

    state_t state;
    state_t state_next;
    side_t  last_served;
    side_t  last_next;

    logic req_i;
    logic req_d;

    assign req_i = i_read | i_write;
    assign req_d = d_read | d_write;

    assign i_rdata = mem_rdata;
    assign d_rdata = mem_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            last_served <= SIDE_I;
        end else begin
            state       <= state_next;
            last_served <= last_next;
        end
    end

    always_comb begin
        state_next  = state;
        last_next   = last_served;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_address = '0;
        mem_wdata   = '0;
        i_resp      = 1'b0;
        d_resp      = 1'b0;

        unique case (state)
            IDLE: begin
                if (req_i && req_d) begin
                    // On a tie the side not served last wins.
                    if (last_served == SIDE_I) begin
                        state_next = SERVE_D;
                        last_next  = SIDE_D;
                    end else begin
                        state_next = SERVE_I;
                        last_next  = SIDE_I;
                    end
                end else if (req_i) begin
                    state_next = SERVE_I;
                    last_next  = SIDE_I;
                end else if (req_d) begin
                    state_next = SERVE_D;
                    last_next  = SIDE_D;
                end
            end
            SERVE_I: begin
                if (req_i) begin
                    mem_write   = i_write;
                    mem_read    = i_read & ~i_write;
                    mem_address = i_address;
                    mem_wdata   = i_wdata;
                end
                if (mem_resp) begin
                    i_resp     = 1'b1;
                    state_next = IDLE;
                end else if (!req_i) begin
                    state_next = IDLE;
                end
            end
            SERVE_D: begin
                if (req_d) begin
                    mem_write   = d_write;
                    mem_read    = d_read & ~d_write;
                    mem_address = d_address;
                    mem_wdata   = d_wdata;
                end
                if (mem_resp) begin
                    d_resp     = 1'b1;
                    state_next = IDLE;
                end else if (!req_d) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Reset abandons any transaction and swallows a coincident mem_resp.
        if (rst) begin
            mem_read    = 1'b0;
            mem_write   = 1'b0;
            mem_address = '0;
            mem_wdata   = '0;
            i_resp      = 1'b0;
            d_resp      = 1'b0;
        end
    end

endmodule

// File: tb/tb_cache_line_arbiter.sv
// Directed bench for cache_line_arbiter: inputs change 1 time unit after a
// rising edge, combinational outputs are checked 1 unit later.
module tb_cache_line_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic         i_read, i_write, d_read, d_write;
    logic [31:0]  i_address, d_address;
    logic [255:0] i_wdata, d_wdata;
    logic         i_resp, d_resp;
    logic [255:0] i_rdata, d_rdata;
    logic         mem_read, mem_write, mem_resp;
    logic [31:0]  mem_address;
    logic [255:0] mem_wdata, mem_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cache_line_arbiter dut (
        .clk(clk), .rst(rst),
        .i_read(i_read), .i_write(i_write),
        .i_address(i_address), .i_wdata(i_wdata),
        .i_resp(i_resp), .i_rdata(i_rdata),
        .d_read(d_read), .d_write(d_write),
        .d_address(d_address), .d_wdata(d_wdata),
        .d_resp(d_resp), .d_rdata(d_rdata),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_address(mem_address), .mem_wdata(mem_wdata),
        .mem_resp(mem_resp), .mem_rdata(mem_rdata)
    );

    task automatic chk(input string tag,
                       input logic [255:0] got,
                       input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_in();
        i_read = 0; i_write = 0; d_read = 0; d_write = 0;
        i_address = '0; d_address = '0;
        i_wdata = '0; d_wdata = '0;
        mem_resp = 0; mem_rdata = '0;
    endtask

    task automatic do_reset();
        clear_in();
        rst = 1;
        cyc();
        cyc();
        rst = 0;
    endtask

    logic [255:0] pat_a5;
    logic [255:0] pat_db;
    logic [255:0] pat_40;
    logic [31:0]  exp_addr;

    initial begin
        pat_a5 = {32{8'hA5}};
        pat_db = {8{32'hDEADBEEF}};
        pat_40 = {8{32'h0404_0404}};
        clear_in();
        rst = 1;
        cyc();
        settle();
        chk("rst_mem_read", mem_read, 0);
        chk("rst_mem_write", mem_write, 0);
        chk("rst_mem_address", mem_address, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_i_resp", i_resp, 0);
        chk("rst_d_resp", d_resp, 0);

        // Single I read, resp at cycle 5, bubble then re-request.
        do_reset();
        i_read = 1; i_address = 32'h0000_1000;
        settle();
        chk("t1_c0_idle", mem_read, 0);
        cyc(); settle();
        chk("t1_c1_mem_read", mem_read, 1);
        chk("t1_c1_addr", mem_address, 32'h1000);
        chk("t1_c1_mem_write", mem_write, 0);
        cyc(); cyc(); cyc(); settle();
        chk("t1_c4_no_resp", i_resp, 0);
        cyc();
        mem_resp = 1; mem_rdata = pat_a5;
        settle();
        chk("t1_c5_i_resp", i_resp, 1);
        chk("t1_c5_i_rdata", i_rdata, pat_a5);
        chk("t1_c5_d_resp", d_resp, 0);
        cyc();
        mem_resp = 0;
        settle();
        chk("t1_c6_bubble", mem_read, 0);
        chk("t1_c6_i_resp", i_resp, 0);
        cyc(); settle();
        chk("t1_c7_regrant", mem_read, 1);
        mem_resp = 1;
        settle();
        chk("t1_c7_i_resp", i_resp, 1);
        cyc();
        clear_in();

        // Tie after reset: D first, then I after one idle cycle.
        do_reset();
        i_read = 1; i_address = 32'h0000_1000;
        d_write = 1; d_address = 32'h0000_2080; d_wdata = pat_db;
        cyc(); settle();
        chk("t2_d_mem_write", mem_write, 1);
        chk("t2_d_mem_read", mem_read, 0);
        chk("t2_d_addr", mem_address, 32'h2080);
        chk("t2_d_wdata", mem_wdata, pat_db);
        mem_resp = 1;
        settle();
        chk("t2_d_resp", d_resp, 1);
        chk("t2_i_resp_low", i_resp, 0);
        cyc();
        mem_resp = 0; d_write = 0;
        settle();
        chk("t2_idle_rd", mem_read, 0);
        chk("t2_idle_wr", mem_write, 0);
        cyc(); settle();
        chk("t2_i_mem_read", mem_read, 1);
        chk("t2_i_addr", mem_address, 32'h1000);
        mem_resp = 1;
        settle();
        chk("t2_i_resp", i_resp, 1);
        cyc();
        clear_in();

        // Continuous contention: grants alternate D,I,D,I,D,I.
        do_reset();
        i_read = 1; i_address = 32'h0000_3000;
        d_read = 1; d_address = 32'h0000_4000;
        for (int k = 0; k < 6; k++) begin
            cyc();
            mem_resp = 1;
            settle();
            exp_addr = (k % 2 == 0) ? 32'h4000 : 32'h3000;
            chk($sformatf("t3_addr_%0d", k), mem_address, exp_addr);
            chk($sformatf("t3_d_resp_%0d", k), d_resp,
                (k % 2 == 0) ? 1'b1 : 1'b0);
            chk($sformatf("t3_i_resp_%0d", k), i_resp,
                (k % 2 == 0) ? 1'b0 : 1'b1);
            cyc();
            mem_resp = 0;
            settle();
            chk($sformatf("t3_bubble_%0d", k), mem_read, 0);
        end
        clear_in();

        // Read+write counts as write; then withdrawal keeps last_served=D.
        do_reset();
        d_read = 1; d_write = 1;
        d_address = 32'h0000_0040; d_wdata = pat_40;
        cyc(); settle();
        chk("t4_mem_write", mem_write, 1);
        chk("t4_mem_read", mem_read, 0);
        chk("t4_addr", mem_address, 32'h40);
        chk("t4_wdata", mem_wdata, pat_40);
        cyc();
        d_read = 0; d_write = 0;
        settle();
        chk("t4_wd_write", mem_write, 0);
        chk("t4_wd_read", mem_read, 0);
        chk("t4_wd_dresp", d_resp, 0);
        cyc();
        i_read = 1; i_address = 32'h0000_5000;
        d_read = 1; d_address = 32'h0000_6000;
        settle();
        chk("t4_idle_addr", mem_address, 0);
        chk("t4_idle_read", mem_read, 0);
        cyc(); settle();
        chk("t4_rr_i_addr", mem_address, 32'h5000);
        mem_resp = 1;
        settle();
        chk("t4_rr_i_resp", i_resp, 1);
        chk("t4_rr_d_resp", d_resp, 0);
        cyc();
        clear_in();

        // Spurious mem_resp in IDLE.
        do_reset();
        mem_resp = 1; mem_rdata = pat_db;
        settle();
        chk("t5_i_resp", i_resp, 0);
        chk("t5_d_resp", d_resp, 0);
        cyc();
        mem_resp = 0;
        i_read = 1; i_address = 32'h0000_7000;
        settle();
        chk("t5_still_idle", mem_read, 0);
        cyc(); settle();
        chk("t5_grant", mem_read, 1);
        mem_resp = 1;
        settle();
        chk("t5_i_resp_ok", i_resp, 1);
        cyc();
        clear_in();

        // Reset in SERVE_I, with mem_resp on and after the reset cycle.
        do_reset();
        i_read = 1; i_address = 32'h0000_8000;
        cyc(); settle();
        chk("t6_serve", mem_read, 1);
        cyc();
        rst = 1; i_read = 0; mem_resp = 1;
        settle();
        chk("t6_rst_i_resp", i_resp, 0);
        chk("t6_rst_mem_read", mem_read, 0);
        chk("t6_rst_addr", mem_address, 0);
        cyc();
        rst = 0; mem_resp = 1;
        settle();
        chk("t6_post_i_resp", i_resp, 0);
        chk("t6_post_mem_read", mem_read, 0);
        chk("t6_post_mem_write", mem_write, 0);
        chk("t6_post_addr", mem_address, 0);
        cyc();
        clear_in();
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
